// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch constants, queue entry type and helpers
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INST  = 32'h0000_0013;
    localparam logic [6:0]  OP_LOAD   = 7'b000_0011;
    localparam logic [6:0]  OP_LOADFP = 7'b000_0111;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic is_load(input logic [31:0] inst);
        return (inst[6:0] == OP_LOAD) || (inst[6:0] == OP_LOADFP);
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small circular FIFO with flush, used for the instruction queue and the PC FIFO
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_pop    = pop && (count != '0);
    assign do_push   = push && ((count != FULL_CNT) || do_pop);
    assign head_data = mem[rptr];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= ptr_inc(wptr);
            if (do_pop)  rptr <= ptr_inc(rptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr] <= push_data;
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) assert (!(push && !flush && (count == FULL_CNT) && !do_pop));
    end
`endif

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - credit-based instruction fetch with in-order response queue and redirect flush
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_hold,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_f_valid,
    output logic [31:0] o_f_pc,
    output logic [31:0] o_f_inst
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_X = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] ZERO_C  = '0;

    logic [31:0]   pc;
    logic [31:0]   last_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] q_count;
    logic [CW-1:0] pcq_count;
    logic [31:0]   pcq_head;
    fetch_entry_t  q_head;
    fetch_entry_t  q_push_data;
    logic          grant;
    logic          rv_live;
    logic          rv_stale;
    logic          q_pop;
    logic          q_push;
    logic [CW:0]   committed;
    logic [CW:0]   discard_redir;

    assign grant    = o_imem_req && i_imem_gnt;
    assign rv_stale = i_imem_rvalid && (discard != ZERO_C);
    assign rv_live  = i_imem_rvalid && (discard == ZERO_C);
    assign q_pop    = o_f_valid && !i_hold && !i_redirect;
    assign q_push   = rv_live && !i_redirect;

    // Slots already spoken for once this cycle's pop retires; stale responses hold no slot.
    assign committed     = {1'b0, q_count} - {ZERO_C, q_pop} + {1'b0, outstanding};
    assign discard_redir = {1'b0, discard} + {1'b0, outstanding} - {ZERO_C, i_imem_rvalid};

    assign o_imem_req  = !i_redirect && (committed < DEPTH_X);
    assign o_imem_addr = pc;
    assign o_f_valid   = (q_count != ZERO_C);
    assign o_f_pc      = o_f_valid ? q_head.pc : last_pc;
    assign o_f_inst    = o_f_valid ? q_head.inst : NOP_INST;

    assign q_push_data.pc   = pcq_head;
    assign q_push_data.inst = i_imem_rdata;

    fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (i_redirect),
        .push      (grant),
        .push_data (pc),
        .pop       (rv_live),
        .head_data (pcq_head),
        .count     (pcq_count)
    );

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_inst_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (i_redirect),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .head_data (q_head),
        .count     (q_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            last_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            if (q_pop) last_pc <= q_head.pc;
            if (i_redirect) begin
                // Everything still in flight becomes stale, minus a response landing right now.
                pc          <= i_redirect_pc;
                outstanding <= '0;
                discard     <= discard_redir[CW-1:0];
            end else begin
                if (grant) pc <= next_pc(pc);
                case ({grant, rv_live})
                    2'b10:   outstanding <= outstanding + CW'(1);
                    2'b01:   outstanding <= outstanding - CW'(1);
                    default: outstanding <= outstanding;
                endcase
                if (rv_stale) discard <= discard - CW'(1);
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(grant && ({1'b0, outstanding} >= DEPTH_X)));
            assert (!(i_redirect && discard_redir[CW]));
            assert (!(i_imem_rvalid && (outstanding == ZERO_C) && (discard == ZERO_C)));
            assert (outstanding == pcq_count);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench with a queue-level reference model of fetch_unit
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        i_hold;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_f_valid;
    logic [31:0] o_f_pc;
    logic [31:0] o_f_inst;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_hold        (i_hold),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_f_valid     (o_f_valid),
        .o_f_pc        (o_f_pc),
        .o_f_inst      (o_f_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; bit stale; } flight_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } entry_t;

    flight_t     inflight[$];
    entry_t      fq[$];
    logic [31:0] m_pc;
    logic [31:0] m_last_pc;
    int          n_pass;
    int          n_total;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    function automatic int live_count();
        int n = 0;
        foreach (inflight[i]) if (!inflight[i].stale) n++;
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        inflight.delete();
        fq.delete();
        m_pc      = RESET_PC;
        m_last_pc = RESET_PC;
    endtask

    // Called at a falling edge: drive one cycle, compare request side, advance model, compare fetch side.
    task automatic step(input bit hold, input bit redir, input logic [31:0] rpc,
                        input bit gnt, input bit resp);
        bit      rv;
        bit      pop;
        bit      m_req;
        bit      ev;
        flight_t f;
        rv = resp && (inflight.size() > 0);
        i_hold        = hold;
        i_redirect    = redir;
        i_redirect_pc = rpc;
        i_imem_gnt    = gnt;
        i_imem_rvalid = rv;
        i_imem_rdata  = rv ? mem_word(inflight[0].addr) : 32'h0;
        pop   = (fq.size() > 0) && !hold && !redir;
        m_req = !redir && ((fq.size() - int'(pop) + live_count()) < DEPTH);
        #1;
        check("imem_req", 32'(o_imem_req), 32'(m_req));
        if (m_req) check("imem_addr", o_imem_addr, m_pc);
        if (pop) begin
            m_last_pc = fq[0].pc;
            fq.delete(0);
        end
        if (rv) begin
            f = inflight.pop_front();
            if (!f.stale && !redir) fq.push_back('{pc: f.addr, inst: mem_word(f.addr)});
        end
        if (redir) begin
            fq.delete();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            m_pc = rpc;
        end
        if (m_req && gnt) begin
            inflight.push_back('{addr: m_pc, stale: 1'b0});
            m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        @(negedge clk);
        ev = fq.size() > 0;
        check("f_valid", 32'(o_f_valid), 32'(ev));
        check("f_pc",    o_f_pc,   ev ? fq[0].pc   : m_last_pc);
        check("f_inst",  o_f_inst, ev ? fq[0].inst : NOP);
    endtask

    task automatic apply_reset();
        #2;
        rst           = 1'b1;
        i_imem_rvalid = 1'b0;
        i_redirect    = 1'b0;
        i_hold        = 1'b0;
        #1;
        check("rst_f_valid", 32'(o_f_valid), 32'h0);
        check("rst_f_inst",  o_f_inst, NOP);
        check("rst_f_pc",    o_f_pc, RESET_PC);
        check("rst_addr",    o_imem_addr, RESET_PC);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("req_after_rst", 32'(o_imem_req), 32'h1);
    endtask

    initial begin
        n_pass        = 0;
        n_total       = 0;
        rst           = 1'b1;
        i_hold        = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'h0;
        i_imem_gnt    = 1'b0;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = 32'h0;
        model_reset();
        @(negedge clk);
        apply_reset();
        @(negedge clk);

        // Streaming with single-cycle memory: 0,4,8,... valid from the third cycle on.
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 32'h0, 1, 1);
            if (k >= 2) begin
                check("stream_valid", 32'(o_f_valid), 32'h1);
                check("stream_pc", o_f_pc, 32'(4 * (k - 2)));
            end
        end

        // Hold for five cycles: queue fills, requests stop, head pinned at 0x18.
        for (int k = 1; k <= 5; k++) begin
            step(1, 0, 32'h0, 1, 1);
            check("hold_pc", o_f_pc, 32'h18);
            check("hold_req", 32'(o_imem_req), 32'h0);
        end
        for (int k = 1; k <= 4; k++) begin
            step(0, 0, 32'h0, 1, 1);
            check("release_pc", o_f_pc, 32'h1C + 32'(4 * (k - 1)));
        end

        // Two requests in flight, redirect to 0x100: both stale responses dropped.
        apply_reset();
        step(0, 0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 1, 0);
        step(0, 1, 32'h100, 1, 0);
        check("redir_valid", 32'(o_f_valid), 32'h0);
        step(0, 0, 32'h0, 1, 1);
        check("stale0_valid", 32'(o_f_valid), 32'h0);
        step(0, 0, 32'h0, 1, 1);
        check("stale1_valid", 32'(o_f_valid), 32'h0);
        step(0, 0, 32'h0, 1, 1);
        check("redir_pc", o_f_pc, 32'h100);
        check("redir_inst", o_f_inst, 32'hC0DE_0100);

        // Grant withheld three cycles: address parked at 0x8 with request up.
        apply_reset();
        step(0, 0, 32'h0, 1, 1);
        step(0, 0, 32'h0, 1, 1);
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 32'h0, 0, 1);
            check("stall_req", 32'(o_imem_req), 32'h1);
            check("stall_addr", o_imem_addr, 32'h8);
        end
        step(0, 0, 32'h0, 1, 1);
        step(0, 0, 32'h0, 1, 1);
        check("resume_valid", 32'(o_f_valid), 32'h1);
        check("resume_pc", o_f_pc, 32'h8);

        // Redirect colliding with a response and a would-be pop, then a second redirect.
        step(0, 1, 32'h200, 1, 1);
        check("collide_valid", 32'(o_f_valid), 32'h0);
        check("collide_inst", o_f_inst, NOP);
        check("collide_pc", o_f_pc, 32'h4);
        step(0, 1, 32'h300, 1, 1);
        step(0, 0, 32'h0, 1, 1);
        step(0, 0, 32'h0, 1, 1);
        check("b2b_valid", 32'(o_f_valid), 32'h1);
        check("b2b_pc", o_f_pc, 32'h300);

        // Reset with two responses outstanding; fetch restarts from RESET_PC.
        apply_reset();
        step(0, 0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 1, 0);
        apply_reset();
        check("restart_addr", o_imem_addr, RESET_PC);
        for (int k = 1; k <= 3; k++) step(0, 0, 32'h0, 1, 1);
        check("restart_valid", 32'(o_f_valid), 32'h1);
        check("restart_pc", o_f_pc, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, instruction queue entries and max in-flight request credit (legal: 2..4).
REQ-003 clk  in  1  clock; all state rising-edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 i_hold  in  1  decode not accepting (OR of stall, ex_stall, ex_mod_stall, load_wait).
REQ-006 i_redirect  in  1  taken jump/branch/trap; flush and refetch.
REQ-007 i_redirect_pc  in  32  target of redirect.
REQ-008 o_imem_req  out  1  instruction memory request.
REQ-009 o_imem_addr  out  32  request address (word aligned).
REQ-010 i_imem_gnt  in  1  request accepted this cycle.
REQ-011 i_imem_rvalid  in  1  read data valid; responses in request order.
REQ-012 i_imem_rdata  in  32  instruction word.
REQ-013 o_f_valid  out  1  queue head valid.
REQ-014 o_f_pc  out  32  PC of queue head (feeds i_f_pc).
REQ-015 o_f_inst  out  32  instruction at queue head (feeds i_f_inst).

Function
REQ-016 Fetch PC register pc SHALL drive o_imem_addr; pc advances by 4 on each cycle with o_imem_req && i_imem_gnt.
REQ-017 o_imem_req SHALL be 1 iff !i_redirect and (queue count + live outstanding) < DEPTH.
REQ-018 Without redirect, o_imem_addr SHALL stay stable while o_imem_req=1 and i_imem_gnt=0.
REQ-019 Outstanding counter SHALL increment on grant, decrement on rvalid; each granted address pushed to an in-order PC FIFO popped on rvalid.
REQ-020 A non-discarded rvalid SHALL push {pc, rdata} into the queue; data visible at o_f_* the following cycle (no bypass).
REQ-021 Queue pop SHALL occur on o_f_valid && !i_hold && !i_redirect; push and pop in the same cycle at full count SHALL be legal.
REQ-022 When queue empty, o_f_valid=0 and o_f_inst SHALL be 32'h0000_0013 (NOP), o_f_pc=pc of last popped entry held.
REQ-023 On i_redirect: pc <= i_redirect_pc, queue emptied, discard counter <= outstanding minus (1 if rvalid this cycle), next cycle o_f_valid=0.
REQ-024 Responses arriving while discard counter > 0 SHALL be dropped and decrement it; they do not consume credit.
REQ-025 Redirect SHALL win over simultaneous pop, push, and grant; a grant in the redirect cycle cannot occur since req=0.
REQ-026 Back-to-back redirects SHALL each reload pc; the last one defines the fetch stream.
REQ-027 Counters SHALL be clog2(DEPTH)+1 bits and never wrap; overflow is a design error flagged by assertion.

Reset
REQ-028 On rst: pc=RESET_PC, queue/outstanding/discard=0, o_f_valid=0, o_f_inst=32'h13, o_f_pc=RESET_PC.
REQ-029 o_imem_req SHALL be 1 in the first cycle after rst deasserts.
REQ-030 rst mid-transaction SHALL abandon all in-flight responses; memory model reset concurrently.

Structure
REQ-031 Shared package holds NOP_INST=32'h0000_0013 and OP_LOAD/OP_LOADFP opcode constants already used by pipeline stall logic.
REQ-032 One sub-module fetch_fifo (parameterised width/depth, push/pop/flush, count) SHALL implement both queue and PC FIFO.

Verification
REQ-033 Reset release, memory gnt=1 with 1-cycle rvalid latency, i_hold=0 -> o_f_pc sequence 0,4,8,... with o_f_valid continuous from third cycle.
REQ-034 i_hold=1 for 5 cycles -> queue fills to 2, o_imem_req=0, o_f_pc held; release -> no PC skipped or repeated.
REQ-035 Two requests in flight, i_redirect to 32'h100 -> both stale responses dropped, next o_f_pc=32'h100.
REQ-036 gnt held low 3 cycles -> o_imem_addr stable at 32'h8 with req=1; fetch proceeds after gnt.
REQ-037 Redirect asserted in same cycle as rvalid and pop -> rvalid data discarded, queue empty, discard count = outstanding-1.
REQ-038 rst asserted with outstanding=2 -> all outputs at reset values same cycle; fetch restarts at RESET_PC.
